// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and the receive-side lock FSM encoding.
// Used by the sync monitor and anything that needs to agree with the display generator.
package vga_timing_pkg;

  localparam int H_TOTAL     = 800;
  localparam int V_TOTAL     = 525;
  localparam int H_SYNC      = 96;
  localparam int H_BACK      = 48;
  localparam int H_ACTIVE    = 640;
  localparam int V_SYNC      = 2;
  localparam int V_BACK      = 33;
  localparam int V_ACTIVE    = 480;
  localparam int LOCK_FRAMES = 2;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } sync_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Rising-edge detector for a sync input; history only advances on pixel samples,
// so the edge pulse is qualified by PixEn.
module sync_edge_det (
  input  logic Clk,
  input  logic Reset,
  input  logic PixEn,
  input  logic Sync_in,
  output logic Rise
);

  logic prev_r;

  // Previous sampled sync level
  always_ff @(posedge Clk) begin
    if (Reset) begin
      prev_r <= 1'b0;
    end else if (PixEn) begin
      prev_r <= Sync_in;
    end else begin
      prev_r <= prev_r;
    end
  end

  assign Rise = PixEn & Sync_in & ~prev_r;

endmodule

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor: measures line/frame lengths, locks after
// consecutive conforming frames, then recovers X/Y and qualifies active pixels.
module vga_sync_monitor
  import vga_timing_pkg::*;
#(
  parameter int P_H_TOTAL     = H_TOTAL,
  parameter int P_V_TOTAL     = V_TOTAL,
  parameter int P_H_SYNC      = H_SYNC,
  parameter int P_H_BACK      = H_BACK,
  parameter int P_H_ACTIVE    = H_ACTIVE,
  parameter int P_V_SYNC      = V_SYNC,
  parameter int P_V_BACK      = V_BACK,
  parameter int P_V_ACTIVE    = V_ACTIVE,
  parameter int P_LOCK_FRAMES = LOCK_FRAMES
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PixEn,
  input  logic        Hsync_in,
  input  logic        Vsync_in,
  input  logic [23:0] Rgb_in,
  output logic        Locked,
  output logic        Pixel_Valid,
  output logic [9:0]  X,
  output logic [9:0]  Y,
  output logic [23:0] Rgb_out,
  output logic        Frame_Start,
  output logic [10:0] Line_Len,
  output logic [10:0] Frame_Lines,
  output logic        Err
);

  localparam logic [10:0] H_LAST  = 11'(P_H_TOTAL - 1);
  localparam logic [10:0] V_LAST  = 11'(P_V_TOTAL - 1);
  localparam logic [10:0] H_START = 11'(P_H_SYNC + P_H_BACK);
  localparam logic [10:0] H_END   = 11'(P_H_SYNC + P_H_BACK + P_H_ACTIVE - 1);
  localparam logic [10:0] V_START = 11'(P_V_SYNC + P_V_BACK);
  localparam logic [10:0] V_END   = 11'(P_V_SYNC + P_V_BACK + P_V_ACTIVE - 1);
  localparam logic [10:0] CNT_MAX = 11'h7FF;
  localparam logic [2:0]  LOCK_N  = 3'(P_LOCK_FRAMES);

  sync_state_e state_r, state_nxt_s;
  logic [10:0] h_cnt_r, v_cnt_r, h_cnt_nxt_s, v_cnt_nxt_s;
  logic [2:0]  good_r, good_nxt_s, good_inc_s;
  logic        line_bad_r, line_bad_nxt_s, err_set_s;
  logic        h_edge_s, v_edge_s;
  logic        h_ok_s, v_ok_s, h_bad_s, v_bad_s, h_miss_s, v_miss_s;
  logic        in_win_s, pix_s;
  logic        locked_r, pix_valid_r, frame_start_r, err_r;
  logic [9:0]  x_r, y_r;
  logic [23:0] rgb_r;
  logic [10:0] line_len_r, frame_lines_r;

  sync_edge_det u_hs_edge (
    .Clk     (Clk),
    .Reset   (Reset),
    .PixEn   (PixEn),
    .Sync_in (Hsync_in),
    .Rise    (h_edge_s)
  );

  sync_edge_det u_vs_edge (
    .Clk     (Clk),
    .Reset   (Reset),
    .PixEn   (PixEn),
    .Sync_in (Vsync_in),
    .Rise    (v_edge_s)
  );

  // A conforming edge arrives exactly when the counter sits on its last value;
  // the miss terms fire on the sample that would push the counter to the total.
  assign h_ok_s     = (h_cnt_r == H_LAST);
  assign v_ok_s     = (v_cnt_r == V_LAST);
  assign h_bad_s    = h_edge_s & ~h_ok_s;
  assign v_bad_s    = v_edge_s & ~v_ok_s;
  assign h_miss_s   = PixEn & ~h_edge_s & h_ok_s;
  assign v_miss_s   = h_edge_s & ~v_edge_s & v_ok_s;
  assign good_inc_s = good_r + 3'd1;

  assign in_win_s = (h_cnt_r >= H_START) && (h_cnt_r <= H_END) &&
                    (v_cnt_r >= V_START) && (v_cnt_r <= V_END);
  assign pix_s    = PixEn & locked_r & in_win_s;

  // Line and frame position counters
  always_comb begin
    h_cnt_nxt_s = h_cnt_r;
    v_cnt_nxt_s = v_cnt_r;
    if (h_edge_s) begin
      h_cnt_nxt_s = 11'd0;
    end else if (PixEn && (h_cnt_r != CNT_MAX)) begin
      h_cnt_nxt_s = h_cnt_r + 11'd1;
    end else begin
      h_cnt_nxt_s = h_cnt_r;
    end
    if (v_edge_s) begin
      v_cnt_nxt_s = 11'd0;
    end else if (h_edge_s && (v_cnt_r != CNT_MAX)) begin
      v_cnt_nxt_s = v_cnt_r + 11'd1;
    end else begin
      v_cnt_nxt_s = v_cnt_r;
    end
  end

  // Lock FSM next state
  always_comb begin
    state_nxt_s    = state_r;
    good_nxt_s     = good_r;
    line_bad_nxt_s = line_bad_r;
    err_set_s      = 1'b0;
    case (state_r)
      SEARCH: begin
        if (v_edge_s) begin
          state_nxt_s    = MEASURE;
          good_nxt_s     = 3'd0;
          line_bad_nxt_s = 1'b0;
        end else begin
          state_nxt_s = SEARCH;
        end
      end
      MEASURE: begin
        if (v_edge_s) begin
          // The line closed by a coincident Hsync belongs to the ending frame
          line_bad_nxt_s = 1'b0;
          if (v_ok_s && !line_bad_r && !h_bad_s) begin
            good_nxt_s = good_inc_s;
            if (good_inc_s == LOCK_N) begin
              state_nxt_s = LOCKED;
            end else begin
              state_nxt_s = MEASURE;
            end
          end else begin
            good_nxt_s = 3'd0;
          end
        end else if (h_bad_s) begin
          line_bad_nxt_s = 1'b1;
        end else begin
          line_bad_nxt_s = line_bad_r;
        end
      end
      LOCKED: begin
        if (h_bad_s || v_bad_s || h_miss_s || v_miss_s) begin
          err_set_s      = 1'b1;
          state_nxt_s    = SEARCH;
          good_nxt_s     = 3'd0;
          line_bad_nxt_s = 1'b0;
        end else begin
          state_nxt_s = LOCKED;
        end
      end
      default: begin
        state_nxt_s    = SEARCH;
        good_nxt_s     = 3'd0;
        line_bad_nxt_s = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r       <= SEARCH;
      h_cnt_r       <= 11'd0;
      v_cnt_r       <= 11'd0;
      good_r        <= 3'd0;
      line_bad_r    <= 1'b0;
      locked_r      <= 1'b0;
      err_r         <= 1'b0;
      frame_start_r <= 1'b0;
      pix_valid_r   <= 1'b0;
      x_r           <= 10'd0;
      y_r           <= 10'd0;
      rgb_r         <= 24'd0;
      line_len_r    <= 11'd0;
      frame_lines_r <= 11'd0;
    end else begin
      state_r       <= state_nxt_s;
      h_cnt_r       <= h_cnt_nxt_s;
      v_cnt_r       <= v_cnt_nxt_s;
      good_r        <= good_nxt_s;
      line_bad_r    <= line_bad_nxt_s;
      locked_r      <= (state_nxt_s == LOCKED);
      err_r         <= err_r | err_set_s;
      frame_start_r <= v_edge_s;
      pix_valid_r   <= pix_s;
      if (pix_s) begin
        x_r   <= 10'(h_cnt_r - H_START);
        y_r   <= 10'(v_cnt_r - V_START);
        rgb_r <= Rgb_in;
      end
      if (h_edge_s) begin
        line_len_r <= h_cnt_r + 11'd1;
      end
      if (v_edge_s) begin
        frame_lines_r <= v_cnt_r + 11'd1;
      end
    end
  end

  assign Locked      = locked_r;
  assign Pixel_Valid = pix_valid_r;
  assign X           = x_r;
  assign Y           = y_r;
  assign Rgb_out     = rgb_r;
  assign Frame_Start = frame_start_r;
  assign Line_Len    = line_len_r;
  assign Frame_Lines = frame_lines_r;
  assign Err         = err_r;

endmodule
